text_overlay: RTL and testbench
===============================

// Module: text_overlay
// PURPOSE
// - Parametrised text-window overlay for the 640x480 VGA pixel path; replaces fixed-string text blocks.
// - Holds a writable COLS x ROWS character buffer and draws it at (ORG_X, ORG_Y), scaled by 2^SCALE_LOG2.
// - Each character takes a per-character palette colour; glyphs come from the existing 8x16 font_rom (1-cycle sync read).
// - Read pipeline is aligned so text_rgb matches the font ROM latency; downstream delays video by LAT cycles.
// PARAMETERS
// - COLS        16     characters per text row (1..64)
// - ROWS        2      text rows (1..16)
// - SCALE_LOG2  1      glyph scale; 8x16 cell drawn as (8<<S)x(16<<S) pixels (0..3)
// - ORG_X       0      window left edge, pixels
// - ORG_Y       0      window top edge, pixels
// - BLINK_FRAMES 32    frames per blink half-period (used only with TEXT_OVERLAY_BLINK_EN)
// - AW          derived, clog2(COLS*ROWS); do not override
// PORTS
// - clk              in   1      pixel clock
// - rst_n            in   1      asynchronous reset, active low
// - pix_x            in   10     current pixel column
// - pix_y            in   10     current pixel row
// - font_background  in   12     background colour; passed through where no glyph bit is set
// - frame_start      in   1      one-cycle pulse per frame (pix_x==0 && pix_y==0)
// - wr_en            in   1      buffer write strobe
// - wr_addr          in   AW     write address = row*COLS + col
// - wr_data          in   10     {blink[9], color_idx[8:7], char_code[6:0]}
// - clr_req          in   1      pulse: fill the buffer with 10'h000
// - busy             out  1      high while the clear sequence runs
// - text_on          out  1      pixel lies inside the text window (delayed LAT)
// - text_rgb         out  12     output colour (delayed LAT)
// BEHAVIOUR
// - Reset values: text_on=0, text_rgb=12'h000, busy=1. All pipeline valid bits are cleared.
// - Latency LAT=3 cycles from pix_x/pix_y/font_background to text_on/text_rgb. The pipeline is always running.
//   S0 (window hit, offsets):
//     dx=pix_x-ORG_X, dy=pix_y-ORG_Y
//     hit = dx < COLS<<(3+S) && dy < ROWS<<(4+S), using unsigned compares. pix_x<ORG_X wraps and reads as a miss.
//   S1: buffer sync read at addr=(dy>>(4+S))*COLS + (dx>>(3+S)).
//       Register bit=(dx>>S)&7 and line=(dy>>S)&15.
//   S2: font_rom addr={char_code,line}.
//   S3: fbit=font_word[7-bit].
//       text_rgb = (hit && fbit && visible) ? PALETTE[color_idx] : font_background (delayed).
// - Buffer read-during-write to the same address returns the OLD data. A write lands from the next pixel cycle on.
// - Clear FSM:
//   - IDLE -> CLEAR on clr_req or on reset release.
//   - CLEAR writes 0 to addr 0..COLS*ROWS-1, one entry per cycle, then returns to IDLE.
//   - busy=1 throughout CLEAR. wr_en is ignored while busy.
//   - clr_req during CLEAR restarts the sweep at addr 0.
// - wr_addr >= COLS*ROWS: the write is dropped.
// - Reset mid-frame or mid-clear: outputs go to reset values at once; a full clear follows.
// - During CLEAR the display shows partially cleared contents; this is not an error.
// CONFIGURATION
// - TEXT_OVERLAY_BLINK_EN defined:
//   - A frame counter counts frame_start pulses. A blink phase bit toggles every BLINK_FRAMES frames.
//   - Reset: counter=0, phase=0 (visible).
//   - Characters with blink=1 are invisible when phase=1; font_background is shown and text_on still follows hit.
// - Not defined:
//   - No counter. wr_data[9] is stored but ignored. visible=1 always.
// STRUCTURE
// - text_overlay_pkg:
//   - PALETTE[0..3] = WHITE 12'hFFF, RED 12'h00F, BLUE 12'hF00, BLACK 12'h000
//   - CHAR_SPACE = 7'h00
//   - char_entry_t bit-field positions
// - Sub-module text_char_buf: dual-port RAM, one write port and one sync read port, old-data on collision.
// - Reuses font_rom unchanged. FSM, address math and pipeline live in text_overlay.
// TESTING
// - Reset, then wait COLS*ROWS cycles -> busy falls after exactly 32 cycles (defaults).
//   Scanning the window gives text_rgb == font_background everywhere.
// - Write addr 0 = {0,2'd1,7'h41} and sweep row y=8 (S=1) -> text_rgb=12'h00F exactly where font_rom(0x41,line 4) bits are 1.
//   Output is 3 cycles after each pixel; all other pixels equal the background.
// - Pixels at x=ORG_X+COLS*16 and y=ORG_Y+ROWS*32, and x<ORG_X with ORG_X=100 -> text_on=0, background passes through.
// - Write addr 5 and read pixel (col5,row0) on the same cycle -> old glyph shown.
//   Next frame -> new glyph shown. wr_addr=40 -> no change.
// - clr_req while busy, and again at addr 10 -> busy lasts 32 cycles from the second pulse.
//   wr_en during busy -> no effect. rst_n low mid-line -> text_on=0 at once.
// - BLINK_EN, BLINK_FRAMES=2, blink char -> visible for frames 0-1, hidden for 2-3, visible from 4.
//   A non-blink char is always visible.

Source files
------------

// File: rtl/text_overlay_pkg.sv
// Shared types and constants for the text overlay: character entry layout,
// clear-FSM states and the 4-entry colour palette.
package text_overlay_pkg;

  localparam int unsigned PIX_W   = 10;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned CHAR_W  = 7;
  localparam int unsigned ENTRY_W = 10;
  localparam int unsigned FONT_AW = 11;

  localparam logic [CHAR_W-1:0] CHAR_SPACE = 7'h00;

  // {blink, color_idx, char_code}, MSB first
  typedef struct packed {
    logic              blink;
    logic [1:0]        color_idx;
    logic [CHAR_W-1:0] char_code;
  } char_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic logic [RGB_W-1:0] palette(input logic [1:0] idx);
    case (idx)
      2'd0:    return 12'hFFF;
      2'd1:    return 12'h00F;
      2'd2:    return 12'hF00;
      default: return 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/font_rom.sv
// 8x16 glyph ROM with a one-cycle registered read; addr = {char_code, line}.
// Only the glyphs currently drawn on screen are populated, all others are blank.
module font_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  logic [7:0] rom_c;

  always_comb begin
    rom_c = 8'h00;
    case (addr)
      11'h412: rom_c = 8'h10;
      11'h413: rom_c = 8'h38;
      11'h414: rom_c = 8'h6C;
      11'h415: rom_c = 8'hC6;
      11'h416: rom_c = 8'hC6;
      11'h417: rom_c = 8'hFE;
      11'h418: rom_c = 8'hC6;
      11'h419: rom_c = 8'hC6;
      11'h41A: rom_c = 8'hC6;
      11'h41B: rom_c = 8'hC6;
      11'h422: rom_c = 8'hFC;
      11'h423: rom_c = 8'h66;
      11'h424: rom_c = 8'h66;
      11'h425: rom_c = 8'h66;
      11'h426: rom_c = 8'h7C;
      11'h427: rom_c = 8'h66;
      11'h428: rom_c = 8'h66;
      11'h429: rom_c = 8'h66;
      11'h42A: rom_c = 8'h66;
      11'h42B: rom_c = 8'hFC;
      default: rom_c = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    data <= rom_c;
  end

endmodule

// File: rtl/text_char_buf.sv
// Character buffer: one write port, one synchronous read port.
// A read of the address being written returns the previous contents.
module text_char_buf
  import text_overlay_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  char_entry_t   wdata,
  input  logic [AW-1:0] raddr,
  output char_entry_t   rdata
);

  char_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_overlay.sv
// Text-window overlay for the 640x480 pixel path, 3-cycle latency to text_on/text_rgb.
// Optional blinking characters when TEXT_OVERLAY_BLINK_EN is defined.
module text_overlay
  import text_overlay_pkg::*;
#(
  parameter int unsigned COLS         = 16,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned SCALE_LOG2   = 1,
  parameter int unsigned ORG_X        = 0,
  parameter int unsigned ORG_Y        = 0,
  parameter int unsigned BLINK_FRAMES = 32,
  parameter int unsigned AW           = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   pix_x,
  input  logic [PIX_W-1:0]   pix_y,
  input  logic [RGB_W-1:0]   font_background,
  input  logic               frame_start,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               clr_req,
  output logic               busy,
  output logic               text_on,
  output logic [RGB_W-1:0]   text_rgb
);

  localparam int unsigned N     = COLS * ROWS;
  localparam int unsigned SH_X  = 3 + SCALE_LOG2;
  localparam int unsigned SH_Y  = 4 + SCALE_LOG2;
  localparam int unsigned WIN_W = COLS << SH_X;
  localparam int unsigned WIN_H = ROWS << SH_Y;

  // ---------------- clear FSM and write port ----------------
  clr_state_e    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          busy_d;
  logic          ram_we_c;
  logic [AW-1:0] ram_waddr_c;
  char_entry_t   ram_wdata_c;
  logic          wr_in_range_c;

  assign wr_in_range_c = 32'(wr_addr) < N;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      busy       <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    ram_we_c    = 1'b0;
    ram_waddr_c = wr_addr;
    ram_wdata_c = char_entry_t'(wr_data);
    case (state_q)
      ST_IDLE: begin
        ram_we_c = wr_en && wr_in_range_c;
        if (clr_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        ram_we_c    = 1'b1;
        ram_waddr_c = clr_addr_q;
        ram_wdata_c = '{blink: 1'b0, color_idx: 2'd0, char_code: CHAR_SPACE};
        if (clr_req) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == AW'(N - 1)) begin
          state_d = ST_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  // ---------------- S0: window hit and buffer address ----------------
  logic [PIX_W-1:0] dx_c, dy_c;
  logic [15:0]      row_c, col_c, lin_c;
  logic             hit_c;
  logic [AW-1:0]    raddr_c;
  logic [2:0]       bit_c;
  logic [3:0]       line_c;

  assign dx_c    = pix_x - PIX_W'(ORG_X);
  assign dy_c    = pix_y - PIX_W'(ORG_Y);
  assign hit_c   = (16'(dx_c) < 16'(WIN_W)) && (16'(dy_c) < 16'(WIN_H));
  assign row_c   = 16'(dy_c >> SH_Y);
  assign col_c   = 16'(dx_c >> SH_X);
  assign lin_c   = row_c * 16'(COLS) + col_c;
  assign raddr_c = hit_c ? AW'(lin_c) : '0;
  assign bit_c   = 3'(dx_c >> SCALE_LOG2);
  assign line_c  = 4'(dy_c >> SCALE_LOG2);

  char_entry_t entry1;

  text_char_buf #(
    .DEPTH (N),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (ram_we_c),
    .waddr (ram_waddr_c),
    .wdata (ram_wdata_c),
    .raddr (raddr_c),
    .rdata (entry1)
  );

  // ---------------- S1: side-band alongside the buffer read ----------------
  logic             hit1;
  logic [2:0]       bit1;
  logic [3:0]       line1;
  logic [RGB_W-1:0] bg1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit1  <= 1'b0;
      bit1  <= '0;
      line1 <= '0;
      bg1   <= '0;
    end else begin
      hit1  <= hit_c;
      bit1  <= bit_c;
      line1 <= line_c;
      bg1   <= font_background;
    end
  end

  // Blink visibility of the character read in S1
  logic vis1_c;

`ifdef TEXT_OVERLAY_BLINK_EN
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FCNT_W-1:0] frame_cnt;
  logic              blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == FCNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign vis1_c = !(entry1.blink && blink_phase);
`else
  logic unused_blink;
  assign unused_blink = ^{entry1.blink, frame_start, BLINK_FRAMES};
  assign vis1_c       = 1'b1;
`endif

  // ---------------- S2: font lookup ----------------
  logic [FONT_AW-1:0] font_addr_c;
  logic [7:0]         font_word;
  logic               hit2, vis2;
  logic [2:0]         bit2;
  logic [1:0]         color2;
  logic [RGB_W-1:0]   bg2;

  assign font_addr_c = {entry1.char_code, line1};

  font_rom u_font (
    .clk  (clk),
    .addr (font_addr_c),
    .data (font_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit2   <= 1'b0;
      vis2   <= 1'b0;
      bit2   <= '0;
      color2 <= '0;
      bg2    <= '0;
    end else begin
      hit2   <= hit1;
      vis2   <= vis1_c;
      bit2   <= bit1;
      color2 <= entry1.color_idx;
      bg2    <= bg1;
    end
  end

  // ---------------- S3: pixel select ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      text_on  <= 1'b0;
      text_rgb <= '0;
    end else begin
      text_on  <= hit2;
      text_rgb <= (hit2 && vis2 && font_word[3'(3'd7 - bit2)]) ? palette(color2) : bg2;
    end
  end

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: default 16x2 window at origin plus a
// 10x3 window at (100,50) sharing the same stimulus.
module tb_text_overlay;
  import text_overlay_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] font_background;
  logic        frame_start, wr_en, clr_req;
  logic [4:0]  wr_addr;
  logic [9:0]  wr_data;
  logic        busy, text_on, busy_b, text_on_b;
  logic [11:0] text_rgb, text_rgb_b;

  int errors = 0;
  int checks = 0;

  localparam logic [9:0] A_RED   = {1'b0, 2'd1, 7'h41};
  localparam logic [9:0] B_WHITE = {1'b0, 2'd0, 7'h42};

  always #5 clk = ~clk;

  text_overlay #(.COLS(16), .ROWS(2), .SCALE_LOG2(1), .ORG_X(0), .ORG_Y(0), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .font_background(font_background),
    .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy), .text_on(text_on), .text_rgb(text_rgb));

  text_overlay #(.COLS(10), .ROWS(3), .SCALE_LOG2(1), .ORG_X(100), .ORG_Y(50), .BLINK_FRAMES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .font_background(font_background),
    .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy_b), .text_on(text_on_b), .text_rgb(text_rgb_b));

  function automatic logic [11:0] bg_of(input int x);
    return 12'(32'h123 + x * 7);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int x, input int y, input logic [11:0] bg);
    pix_x = 10'(x);
    pix_y = 10'(y);
    font_background = bg;
  endtask

  task automatic probe(input int x, input int y, input logic [11:0] bg);
    set_pix(x, y, bg);
    repeat (3) tick();
  endtask

  task automatic write_entry(input int addr, input logic [9:0] data);
    wr_en = 1'b1;
    wr_addr = 5'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Stream one pixel per cycle along row y; output for pixel k appears 3 cycles later
  task automatic sweep(input int y, input int n, input logic [15:0] mask, input logic [11:0] col,
                       input string tag);
    logic [11:0] exp_rgb;
    int px;
    for (int k = 0; k < n + 3; k++) begin
      tick();
      if (k >= 3) begin
        px = k - 3;
        exp_rgb = (px < 16 && mask[px[3:0]]) ? col : bg_of(px);
        checks++;
        if (text_rgb !== exp_rgb) begin
          errors++;
          $display("FAIL %s_rgb x=%0d: got %h want %h", tag, px, text_rgb, exp_rgb);
        end
        checks++;
        if (text_on !== 1'b1) begin
          errors++;
          $display("FAIL %s_on x=%0d: got %b want 1", tag, px, text_on);
        end
        checks++;
        if (text_on_b !== 1'b0 || text_rgb_b !== bg_of(px)) begin
          errors++;
          $display("FAIL %s_b x=%0d: got on=%b rgb=%h want on=0 rgb=%h", tag, px, text_on_b,
                   text_rgb_b, bg_of(px));
        end
      end
      if (k < n) set_pix(k, y, bg_of(k));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_pix(0, 0, 12'h777);
    repeat (2) tick();
    checks++;
    if (text_on !== 1'b0 || text_rgb !== 12'h000) begin
      errors++;
      $display("FAIL reset_out: got on=%b rgb=%h want on=0 rgb=000", text_on, text_rgb);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b want 1", busy);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      checks++;
      if (busy !== (k < 32)) begin
        errors++;
        $display("FAIL reset_clear_len k=%0d: got busy=%b want %b", k, busy, (k < 32));
      end
    end
  endtask

  task automatic test_blank();
    sweep(8, 32, 16'h0000, 12'h000, "blank_row0");
    sweep(40, 32, 16'h0000, 12'h000, "blank_row1");
  endtask

  task automatic test_glyph();
    write_entry(0, A_RED);
    // font 'A' line 4 = 0x6C, each glyph bit two pixels wide
    sweep(8, 32, 16'h0F3C, 12'h00F, "glyph_a");
    write_entry(31, A_RED);
    probe(242, 40, 12'h0A0);
    checks++;
    if (text_rgb !== 12'h00F) begin
      errors++;
      $display("FAIL glyph_last_set: got %h want 00f", text_rgb);
    end
    probe(240, 40, 12'h0A0);
    checks++;
    if (text_rgb !== 12'h0A0) begin
      errors++;
      $display("FAIL glyph_last_clear: got %h want 0a0", text_rgb);
    end
  endtask

  task automatic test_bounds();
    probe(255, 8, 12'h111);
    checks++;
    if (text_on !== 1'b1 || text_rgb !== 12'h111) begin
      errors++;
      $display("FAIL bound_x_in: got on=%b rgb=%h want on=1 rgb=111", text_on, text_rgb);
    end
    probe(256, 8, 12'h222);
    checks++;
    if (text_on !== 1'b0 || text_rgb !== 12'h222) begin
      errors++;
      $display("FAIL bound_x_out: got on=%b rgb=%h want on=0 rgb=222", text_on, text_rgb);
    end
    probe(0, 63, 12'h333);
    checks++;
    if (text_on !== 1'b1) begin
      errors++;
      $display("FAIL bound_y_in: got on=%b want 1", text_on);
    end
    probe(0, 64, 12'h444);
    checks++;
    if (text_on !== 1'b0 || text_rgb !== 12'h444) begin
      errors++;
      $display("FAIL bound_y_out: got on=%b rgb=%h want on=0 rgb=444", text_on, text_rgb);
    end
    probe(99, 58, 12'h555);
    checks++;
    if (text_on_b !== 1'b0 || text_rgb_b !== 12'h555) begin
      errors++;
      $display("FAIL org_left_miss: got on=%b rgb=%h want on=0 rgb=555", text_on_b, text_rgb_b);
    end
    probe(104, 58, 12'h666);
    checks++;
    if (text_on_b !== 1'b1 || text_rgb_b !== 12'h00F) begin
      errors++;
      $display("FAIL org_glyph: got on=%b rgb=%h want on=1 rgb=00f", text_on_b, text_rgb_b);
    end
    probe(260, 58, 12'h777);
    checks++;
    if (text_on_b !== 1'b0) begin
      errors++;
      $display("FAIL org_right_miss: got on=%b want 0", text_on_b);
    end
    probe(259, 145, 12'h888);
    checks++;
    if (text_on_b !== 1'b1 || text_rgb_b !== 12'h888) begin
      errors++;
      $display("FAIL org_corner_in: got on=%b rgb=%h want on=1 rgb=888", text_on_b, text_rgb_b);
    end
    probe(104, 146, 12'h999);
    checks++;
    if (text_on_b !== 1'b0) begin
      errors++;
      $display("FAIL org_bottom_miss: got on=%b want 0", text_on_b);
    end
  endtask

  task automatic test_read_during_write();
    wr_en = 1'b1;
    wr_addr = 5'd5;
    wr_data = B_WHITE;
    set_pix(80, 4, 12'hABC);
    tick();
    wr_en = 1'b0;
    set_pix(200, 60, 12'h321);
    tick();
    set_pix(80, 4, 12'h456);
    tick();
    checks++;
    if (text_rgb !== 12'hABC) begin
      errors++;
      $display("FAIL rdw_old: got %h want abc", text_rgb);
    end
    tick();
    checks++;
    if (text_rgb !== 12'h321) begin
      errors++;
      $display("FAIL rdw_next_pixel: got %h want 321", text_rgb);
    end
    tick();
    checks++;
    if (text_rgb !== 12'hFFF) begin
      errors++;
      $display("FAIL rdw_new: got %h want fff", text_rgb);
    end
    probe(92, 4, 12'h246);
    checks++;
    if (text_rgb !== 12'h246) begin
      errors++;
      $display("FAIL rdw_new_zero_bit: got %h want 246", text_rgb);
    end
    // address 30 is past the end of the 10x3 buffer
    write_entry(30, B_WHITE);
    probe(104, 58, 12'h135);
    checks++;
    if (text_rgb_b !== 12'h00F) begin
      errors++;
      $display("FAIL oob_write: got %h want 00f", text_rgb_b);
    end
  endtask

  task automatic test_clear();
    write_entry(3, A_RED);
    probe(50, 8, 12'h0C0);
    checks++;
    if (text_rgb !== 12'h00F) begin
      errors++;
      $display("FAIL clear_pre: got %h want 00f", text_rgb);
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_start: got busy=%b want 1", busy);
    end
    repeat (10) tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      checks++;
      if (busy !== (k < 32)) begin
        errors++;
        $display("FAIL clear_restart_len k=%0d: got busy=%b want %b", k, busy, (k < 32));
      end
      if (k == 20) begin
        wr_en = 1'b1;
        wr_addr = 5'd3;
        wr_data = A_RED;
      end
      if (k == 21) wr_en = 1'b0;
    end
    probe(50, 8, 12'h0C0);
    checks++;
    if (text_rgb !== 12'h0C0) begin
      errors++;
      $display("FAIL clear_busy_write: got %h want 0c0", text_rgb);
    end
    probe(2, 8, 12'h0C1);
    checks++;
    if (text_rgb !== 12'h0C1) begin
      errors++;
      $display("FAIL clear_addr0: got %h want 0c1", text_rgb);
    end
  endtask

  task automatic test_reset_mid();
    write_entry(0, A_RED);
    probe(2, 8, 12'h0D0);
    checks++;
    if (text_on !== 1'b1 || text_rgb !== 12'h00F) begin
      errors++;
      $display("FAIL mid_pre: got on=%b rgb=%h want on=1 rgb=00f", text_on, text_rgb);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (text_on !== 1'b0 || text_rgb !== 12'h000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got on=%b rgb=%h busy=%b want on=0 rgb=000 busy=1", text_on,
               text_rgb, busy);
    end
    tick();
    rst_n = 1'b1;
    repeat (32) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear_done: got busy=%b want 0", busy);
    end
    probe(2, 8, 12'h0D1);
    checks++;
    if (text_rgb !== 12'h0D1) begin
      errors++;
      $display("FAIL mid_cleared: got %h want 0d1", text_rgb);
    end
  endtask

  task automatic test_blink();
    logic blink_en;
    logic [11:0] exp_rgb;
`ifdef TEXT_OVERLAY_BLINK_EN
    blink_en = 1'b1;
`else
    blink_en = 1'b0;
`endif
    write_entry(0, {1'b1, 2'd1, 7'h41});
    write_entry(1, A_RED);
    for (int f = 0; f <= 4; f++) begin
      probe(2, 8, 12'h0E0);
      exp_rgb = (blink_en && (f == 2 || f == 3)) ? 12'h0E0 : 12'h00F;
      checks++;
      if (text_rgb !== exp_rgb || text_on !== 1'b1) begin
        errors++;
        $display("FAIL blink_char f=%0d: got on=%b rgb=%h want on=1 rgb=%h", f, text_on,
                 text_rgb, exp_rgb);
      end
      probe(18, 8, 12'h0E1);
      checks++;
      if (text_rgb !== 12'h00F) begin
        errors++;
        $display("FAIL steady_char f=%0d: got %h want 00f", f, text_rgb);
      end
      set_pix(0, 0, 12'h000);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
  endtask

  initial begin
    frame_start = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clr_req = 1'b0;
    set_pix(0, 0, 12'h000);
    test_reset();
    test_blank();
    test_glyph();
    test_bounds();
    test_read_during_write();
    test_clear();
    test_reset_mid();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
